neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_sequencer.sv | 118 +++++++++++
 tb/tb_neuron_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sequencer.sv
// Sequences bias then INPUT_SIZE weight/input MACs into an external arithmetic unit and holds the result.
// Result valid 2*INPUT_SIZE+3 cycles after BIAS with inputs streaming; one input per two cycles, result held until yumi_i.
module neuron_sequencer #(
    parameter int WORD_SIZE  = 16,
    parameter int INPUT_SIZE = 4,
    parameter int RELU       = 1,
    localparam int AW        = $clog2(INPUT_SIZE + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [AW-1:0]        mem_addr_o,
    input  logic [WORD_SIZE-1:0] mem_data_i,
    output logic [WORD_SIZE-1:0] lu_mem_o,
    output logic [WORD_SIZE-1:0] lu_data_o,
    output logic                 lu_add_bias_o,
    output logic                 lu_sum_en_o,
    output logic                 lu_reset_o,
    input  logic [WORD_SIZE-1:0] lu_data_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 valid_o,
    input  logic                 yumi_i
);

    typedef enum logic [2:0] {
        S_BIAS,
        S_BIAS_ADD,
        S_WAIT_W,
        S_MAC,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(INPUT_SIZE - 1);

    state_t               state;
    logic [AW-1:0]        cnt;
    logic [WORD_SIZE-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= S_BIAS;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                S_BIAS: begin
                    cnt   <= '0;
                    state <= S_BIAS_ADD;
                end
                S_BIAS_ADD: state <= S_WAIT_W;
                S_WAIT_W:   state <= S_MAC;
                S_MAC: begin
                    if (valid_i) begin
                        // cnt parks on the last index so the address never runs past INPUT_SIZE
                        if (cnt == LAST) begin
                            state <= S_CAPTURE;
                        end else begin
                            cnt   <= cnt + AW'(1);
                            state <= S_WAIT_W;
                        end
                    end
                end
                S_CAPTURE: begin
                    data_q <= (RELU != 0 && lu_data_i[WORD_SIZE-1]) ? '0 : lu_data_i;
                    state  <= S_DONE;
                end
                S_DONE: if (yumi_i) state <= S_BIAS;
                default: state <= S_BIAS;
            endcase
        end
    end

    always_comb begin
        ready_o       = 1'b0;
        valid_o       = 1'b0;
        mem_addr_o    = '0;
        lu_mem_o      = '0;
        lu_data_o     = '0;
        lu_add_bias_o = 1'b0;
        lu_sum_en_o   = 1'b0;
        case (state)
            S_BIAS_ADD: begin
                lu_mem_o      = mem_data_i;
                lu_add_bias_o = 1'b1;
                lu_sum_en_o   = 1'b1;
                mem_addr_o    = AW'(1);
            end
            S_WAIT_W: mem_addr_o = cnt + AW'(1);
            S_MAC: begin
                mem_addr_o = cnt + AW'(1);
                ready_o    = 1'b1;
                if (valid_i) begin
                    lu_data_o   = data_i;
                    lu_mem_o    = mem_data_i;
                    lu_sum_en_o = 1'b1;
                end
            end
            S_DONE:  valid_o = 1'b1;
            default: ;
        endcase
        // reset must silence the handshake and accumulate controls before the state register catches up
        if (reset_i) begin
            ready_o       = 1'b0;
            valid_o       = 1'b0;
            lu_mem_o      = '0;
            lu_data_o     = '0;
            lu_add_bias_o = 1'b0;
            lu_sum_en_o   = 1'b0;
        end
    end

    assign lu_reset_o = reset_i || (state == S_BIAS);
    assign data_o     = data_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Drives a RELU=1 and a RELU=0 sequencer in lockstep against a Q8.8 arithmetic unit and weight memory;
// a dot-product reference model checks every accept and every valid result.
module tb_neuron_sequencer;

    localparam int N  = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, valid_i, yumi_i;
    logic [15:0] data_i;

    logic          ready[2], add_bias[2], sum_en[2], lu_rst[2], vld[2];
    logic [AW-1:0] addr[2];
    logic [15:0]   mem_q[2], lu_mem[2], lu_data[2], sum[2], dout[2];
    logic [15:0]   wmem[8];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    neuron_sequencer #(.WORD_SIZE(16), .INPUT_SIZE(N), .RELU(1)) u_relu (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready[0]),
        .mem_addr_o(addr[0]), .mem_data_i(mem_q[0]), .lu_mem_o(lu_mem[0]), .lu_data_o(lu_data[0]),
        .lu_add_bias_o(add_bias[0]), .lu_sum_en_o(sum_en[0]), .lu_reset_o(lu_rst[0]),
        .lu_data_i(sum[0]), .data_o(dout[0]), .valid_o(vld[0]), .yumi_i(yumi_i)
    );

    neuron_sequencer #(.WORD_SIZE(16), .INPUT_SIZE(N), .RELU(0)) u_lin (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready[1]),
        .mem_addr_o(addr[1]), .mem_data_i(mem_q[1]), .lu_mem_o(lu_mem[1]), .lu_data_o(lu_data[1]),
        .lu_add_bias_o(add_bias[1]), .lu_sum_en_o(sum_en[1]), .lu_reset_o(lu_rst[1]),
        .lu_data_i(sum[1]), .data_o(dout[1]), .valid_o(vld[1]), .yumi_i(yumi_i)
    );

    function automatic logic [15:0] q88_mul(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = $signed(a) * $signed(b);
        p = p >>> 8;
        return p[15:0];
    endfunction

    // Environment: registered weight memory and Q8.8 accumulator
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_q[i] <= wmem[addr[i]];
            if (lu_rst[i])
                sum[i] <= 16'h0000;
            else if (sum_en[i])
                sum[i] <= add_bias[i] ? sum[i] + lu_mem[i] : sum[i] + q88_mul(lu_data[i], lu_mem[i]);
        end
    end

    // Reference: y = bias + sum_k (x_k * w_k) in Q8.8, optionally clamped at zero
    function automatic logic [15:0] model(input logic [3:0][15:0] xs, input bit relu);
        int acc;
        logic [15:0] r;
        acc = $signed(wmem[0]);
        for (int k = 0; k < N; k++)
            acc = acc + ((int'($signed(xs[k])) * int'($signed(wmem[k+1]))) >>> 8);
        r = acc[15:0];
        if (relu && r[15]) r = 16'h0000;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int               nacc[2];
    bit               seen[2];
    logic [15:0]      expv[2];
    logic [3:0][15:0] accd[2];

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (reset_i) begin
                nacc[i] = 0;
                seen[i] = 0;
                chk("rst_ready", ready[i], 0);
                chk("rst_valid", vld[i], 0);
                chk("rst_lu_reset", lu_rst[i], 1);
                chk("rst_sum_en", sum_en[i], 0);
                chk("rst_add_bias", add_bias[i], 0);
            end else begin
                chk("addr_range", addr[i] > 3'd4, 0);
                chk("ready_and_valid", ready[i] && vld[i], 0);
                if (lu_rst[i]) begin
                    nacc[i] = 0;
                    seen[i] = 0;
                    chk("bias_addr", addr[i], 0);
                end
                if (ready[i] && valid_i) begin
                    chk("accept_count", nacc[i] < N, 1);
                    chk("accept_sum_en", sum_en[i], 1);
                    if (nacc[i] < N) begin
                        chk("accept_lu_data", lu_data[i], data_i);
                        chk("accept_lu_mem", lu_mem[i], wmem[nacc[i]+1]);
                        chk("accept_addr", addr[i], nacc[i] + 1);
                        accd[i][nacc[i]] = data_i;
                        nacc[i]++;
                    end
                end else if (ready[i]) begin
                    chk("idle_sum_en", sum_en[i], 0);
                end
                if (vld[i]) begin
                    if (!seen[i]) begin
                        expv[i] = model(accd[i], i == 0);
                        seen[i] = 1;
                        chk("accepts_at_valid", nacc[i], N);
                    end
                    chk("data_o", dout[i], expv[i]);
                end else begin
                    seen[i] = 0;
                end
            end
        end
    end

    // Entered and left at a negedge with both sequencers in BIAS
    task automatic run_pass(input logic [3:0][15:0] xs, input int gap_at, input int gap_len,
                            input int hold, input bit yumi_noise,
                            output logic [15:0] r0, output logic [15:0] r1, output int lat);
        int k = 0;
        int g = 0;
        int budget = 0;
        int t0;
        bit acc_now;
        t0  = cyc;
        lat = -1;
        r0  = 16'hxxxx;
        r1  = 16'hxxxx;
        while (!vld[0] && budget < 200) begin
            yumi_i = yumi_noise;
            if (k == gap_at && g < gap_len && ready[0]) begin
                valid_i = 1'b0;
                g++;
                #1;
                chk("gap_ready", ready[0], 1);
                chk("gap_addr", addr[0], gap_at + 1);
                chk("gap_sum_en", sum_en[0], 0);
            end else begin
                valid_i = 1'b1;
                data_i  = (k < N) ? xs[k] : 16'h7FFF;
            end
            acc_now = ready[0] && valid_i;
            @(posedge clk);
            if (acc_now) k++;
            @(negedge clk);
            budget++;
        end
        yumi_i = 1'b0;
        if (!vld[0]) begin
            chk("valid_timeout", 0, 1);
            return;
        end
        lat     = cyc - t0;
        r0      = dout[0];
        r1      = dout[1];
        valid_i = 1'b1;
        data_i  = 16'h7FFF;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("hold_valid", vld[0], 1);
        end
        yumi_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        yumi_i = 1'b0;
        #1;
        chk("post_yumi_addr", addr[0], 0);
        chk("post_yumi_lu_reset", lu_rst[0], 1);
        chk("post_yumi_valid", vld[0], 0);
    endtask

    task automatic set_w(input logic [15:0] b, input logic [3:0][15:0] w);
        wmem[0] = b;
        for (int k = 0; k < N; k++) wmem[k+1] = w[k];
        for (int k = N + 1; k < 8; k++) wmem[k] = 16'h0000;
    endtask

    logic [15:0] r0, r1;
    int          lat;

    initial begin
        int k = 0;
        int budget = 0;
        bit acc_now;
        reset_i = 1'b1;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        data_i  = 16'h0000;
        set_w(16'h0100, {4{16'h0100}});
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_data_o_relu", dout[0], 0);
        chk("reset_data_o_lin", dout[1], 0);
        chk("reset_addr", addr[0], 0);
        reset_i = 1'b0;

        // all-ones bias/weights/inputs, valid held high, result held 5 cycles, yumi noise while busy
        run_pass({4{16'h0100}}, -1, 0, 5, 1'b1, r0, r1, lat);
        chk("A_relu", r0, 16'h0500);
        chk("A_lin", r1, 16'h0500);
        chk("A_latency", lat, 11);

        // negative bias: clamped by ReLU, passed by the linear instance
        set_w(16'hFE00, {4{16'h0100}});
        run_pass({4{16'h0000}}, -1, 0, 0, 1'b0, r0, r1, lat);
        chk("B_relu", r0, 16'h0000);
        chk("B_lin", r1, 16'hFE00);
        chk("B_latency", lat, 11);

        // three idle MAC cycles before input 2
        set_w(16'h0100, {4{16'h0100}});
        run_pass({4{16'h0100}}, 2, 3, 0, 1'b0, r0, r1, lat);
        chk("C_relu", r0, 16'h0500);
        chk("C_latency", lat, 14);

        // abort after two inputs with reset in MAC
        while (k < 2 && budget < 50) begin
            valid_i = 1'b1;
            data_i  = 16'h0300;
            acc_now = ready[0];
            @(posedge clk);
            if (acc_now) k++;
            @(negedge clk);
            budget++;
        end
        valid_i = 1'b0;
        while (!ready[0] && budget < 50) begin
            @(posedge clk);
            @(negedge clk);
            budget++;
        end
        chk("abort_reached_mac", ready[0], 1);
        reset_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("abort_data_o", dout[0], 0);
        chk("abort_addr", addr[0], 0);
        chk("abort_lu_reset", lu_rst[0], 1);
        set_w(16'h0000, {4{16'h0100}});
        reset_i = 1'b0;
        run_pass({4{16'h0200}}, -1, 0, 0, 1'b0, r0, r1, lat);
        chk("D_relu", r0, 16'h0800);
        chk("D_lin", r1, 16'h0800);
        chk("D_latency", lat, 11);

        // mixed signs: 0.5 + 1*2 + 2*(-1) + 4*0.5 + (-0.5)*1 = 2.0
        set_w(16'h0080, {16'h0100, 16'h0080, 16'hFF00, 16'h0200});
        run_pass({16'hFF80, 16'h0400, 16'h0200, 16'h0100}, -1, 0, 1, 1'b0, r0, r1, lat);
        chk("E_relu", r0, 16'h0200);
        chk("E_lin", r1, 16'h0200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
